// File: rtl/dn_mem_arbiter.sv
// dn_mem_arbiter
//   Shares one single-port synchronous RAM between the CPU bus and the HPS
//   ioctl download stream. Download writes for SEL_INDEX are buffered in a
//   small FIFO so the CPU keeps running while a file streams in. A scheduler
//   alternates between the two requesters, with a full FIFO overriding the
//   CPU so downloads never back up indefinitely.
//
// Ports
//   clk_sys, reset_n        system clock, synchronous active-low reset
//   dn_wr/index/addr/data   ioctl download write stream (single-cycle strobes)
//   dn_busy                 FIFO holds data or a download write is being issued
//   dn_overflow             sticky: a qualifying download write was dropped
//   cpu_req/we/addr/din     CPU request, held stable until cpu_ack
//   cpu_ack, cpu_dout       one-cycle completion pulse, read data (held)
//   mem_addr/we/din         registered RAM controls
//   mem_dout                RAM read data, one cycle after mem_addr
module dn_mem_arbiter #(
  parameter int         AW         = 17,
  parameter int         DW         = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] SEL_INDEX  = 8'd3
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          dn_wr,
  input  logic [7:0]    dn_index,
  input  logic [AW-1:0] dn_addr,
  input  logic [DW-1:0] dn_data,
  output logic          dn_busy,
  output logic          dn_overflow,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_dout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DN_ISSUE  = 2'd1,
    CPU_ISSUE = 2'd2,
    CPU_WAIT  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic          last_cpu;   // most recent grant went to the CPU
  logic          cpu_read;   // CPU access currently in flight is a read
  logic [DW-1:0] dout_hold;

  logic          fifo_empty;
  logic          fifo_full;
  logic          qualify;
  logic          grant_dn;
  logic          grant_cpu;
  logic          push;
  logic          pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign qualify    = dn_wr && (dn_index == SEL_INDEX);

  // Scheduler: next state and grant decision
  always_comb begin
    state_next = IDLE;
    grant_dn   = 1'b0;
    grant_cpu  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_full) begin
          grant_dn   = 1'b1;
          state_next = DN_ISSUE;
        end else if (cpu_req && (fifo_empty || !last_cpu)) begin
          grant_cpu  = 1'b1;
          state_next = CPU_ISSUE;
        end else if (!fifo_empty) begin
          grant_dn   = 1'b1;
          state_next = DN_ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      DN_ISSUE:  state_next = IDLE;
      CPU_ISSUE: state_next = CPU_WAIT;
      CPU_WAIT:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The head leaves the FIFO on the same edge that enters DN_ISSUE. A slot
  // freed by that pop can take a write arriving in the same cycle, which is
  // what lets a back-to-back burst drain without loss.
  assign pop  = grant_dn;
  assign push = qualify && (!fifo_full || pop);

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wr_ptr] <= dn_addr;
      fifo_data[wr_ptr] <= dn_data;
    end
  end

  // State, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      last_cpu    <= 1'b0;
      cpu_read    <= 1'b0;
      dout_hold   <= '0;
      dn_overflow <= 1'b0;
      cpu_ack     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_din     <= '0;
    end else begin
      state <= state_next;

      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + (PW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PW+1)'(1);
      end

      if (qualify && !push) begin
        dn_overflow <= 1'b1;
      end

      if (state == DN_ISSUE) begin
        last_cpu <= 1'b0;
      end else if (state == CPU_ISSUE) begin
        last_cpu <= 1'b1;
      end

      // Ack is asserted for the whole CPU_WAIT cycle
      cpu_ack <= (state_next == CPU_WAIT);

      if (state == CPU_WAIT && cpu_read) begin
        dout_hold <= mem_dout;
      end

      if (grant_dn) begin
        mem_addr <= fifo_addr[rd_ptr];
        mem_din  <= fifo_data[rd_ptr];
        mem_we   <= 1'b1;
      end else if (grant_cpu) begin
        mem_addr <= cpu_addr;
        mem_din  <= cpu_din;
        mem_we   <= cpu_we;
        cpu_read <= !cpu_we;
      end else begin
        mem_we   <= 1'b0;
      end
    end
  end

  // Read data is forwarded straight from the RAM during the ack cycle and
  // held afterwards until the next read completes.
  assign cpu_dout = (state == CPU_WAIT && cpu_read) ? mem_dout : dout_hold;
  assign dn_busy  = !fifo_empty || (state == DN_ISSUE);

endmodule
